// File: rtl/player_pkg.sv
// player_pkg: shared constants for the music player sequencer.
// State encoding is fixed so debug LEDs on state_o stay stable across builds.
package player_pkg;

  localparam int SONG_W = 2;

  // FSM state encoding
  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_PAUSE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;

  // State to return to when leaving NEXT
  localparam logic RES_PAUSE = 1'b0;
  localparam logic RES_PLAY  = 1'b1;

  // Advance the song index, wrapping after the last song in ROM
  function automatic logic [SONG_W-1:0] song_inc(input logic [SONG_W-1:0] s,
                                                 input int num_songs);
    if (s == SONG_W'(num_songs - 1)) return '0;
    return s + 1'b1;
  endfunction

endpackage

// File: rtl/gap_timer.sv
// gap_timer: loadable down-counter that times the silence between songs.
// Loads GAP_CYCLES-1, counts down while enabled, holds at zero.
module gap_timer #(
  parameter int GAP_CYCLES = 1000,
  localparam int W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam logic [W-1:0] LOAD_V = W'(GAP_CYCLES - 1);

  logic [W-1:0] cnt_q;

  // Load on gap entry, otherwise count down to zero and stick there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  cnt_q <= '0;
    else if (load_i)               cnt_q <= LOAD_V;
    else if (en_i && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/player_mcu.sv
// player_mcu: play/pause/next sequencer with a silent gap between songs.
// Optional feature macro: PLAYER_REPEAT_EN -- when defined the playlist loops
// forever; otherwise an auto-advance past the last song lands in PAUSE.
module player_mcu
  import player_pkg::*;
#(
  parameter int NUM_SONGS  = 4,
  parameter int GAP_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play_btn,
  input  logic              next_btn,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic [2:0]        state_o
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  logic [2:0]        state_q, state_d;
  logic              resume_q, resume_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic              gap_load, gap_zero;
  logic              auto_resume;

  // Where an expired gap goes once the next song is selected
`ifdef PLAYER_REPEAT_EN
  assign auto_resume = RES_PLAY;
`else
  assign auto_resume = (song_q == LAST_SONG) ? RES_PAUSE : RES_PLAY;
`endif

  // Next-state, resume and song selection; next_btn outranks every other input
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    song_d   = song_q;
    gap_load = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (next_btn) begin
          state_d  = ST_NEXT;
          resume_d = RES_PAUSE;
        end else if (play_btn) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (next_btn) begin
          state_d  = ST_NEXT;
          resume_d = RES_PLAY;
        end else if (song_done) begin
          state_d  = ST_GAP;
          gap_load = 1'b1;
        end else if (play_btn) begin
          state_d = ST_PAUSE;
        end
      end
      ST_GAP: begin
        if (next_btn) begin
          state_d  = ST_NEXT;
          resume_d = RES_PLAY;
        end else if (play_btn) begin
          state_d  = ST_NEXT;
          resume_d = RES_PAUSE;
        end else if (gap_zero) begin
          state_d  = ST_NEXT;
          resume_d = auto_resume;
        end
      end
      ST_NEXT: begin
        // New index appears on the exit edge while reset_player is still high
        state_d = (resume_q == RES_PLAY) ? ST_PLAY : ST_PAUSE;
        song_d  = song_inc(song_q, NUM_SONGS);
      end
      default: state_d = ST_RST;
    endcase
  end

  // State, resume and song registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RST;
      resume_q <= RES_PAUSE;
      song_q   <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      song_q   <= song_d;
    end
  end

  gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (gap_load),
    .en_i    (state_q == ST_GAP),
    .zero_o  (gap_zero)
  );

  assign play         = (state_q == ST_PLAY);
  assign reset_player = (state_q == ST_RST) || (state_q == ST_NEXT);
  assign song         = song_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_player_mcu.sv
// tb_player_mcu: directed checks of the player sequencer with a 5-cycle gap.
module tb_player_mcu;
  import player_pkg::*;

  localparam int GAP = 5;

  logic       clk = 1'b0;
  logic       reset_n, play_btn, next_btn, song_done;
  logic       play, reset_player;
  logic [1:0] song;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;

  player_mcu #(.NUM_SONGS(4), .GAP_CYCLES(GAP)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .play_btn     (play_btn),
    .next_btn     (next_btn),
    .song_done    (song_done),
    .play         (play),
    .reset_player (reset_player),
    .song         (song),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the expected state/song
  task automatic chk_all(input string tag, input logic [2:0] st, input logic [1:0] sg);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".song"}, 32'(song), 32'(sg));
    chk({tag, ".play"}, 32'(play), 32'(st == ST_PLAY));
    chk({tag, ".rstp"}, 32'(reset_player), 32'((st == ST_RST) || (st == ST_NEXT)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the given inputs for exactly one sampling edge
  task automatic pulse(input logic p, input logic n, input logic d);
    play_btn = p; next_btn = n; song_done = d;
    tick();
    play_btn = 1'b0; next_btn = 1'b0; song_done = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; play_btn = 1'b0; next_btn = 1'b0; song_done = 1'b0;

    // Reset held for three cycles
    repeat (3) tick();
    chk_all("in_reset", ST_RST, 2'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_rstp", 32'(reset_player), 32'd1);
    tick();
    chk_all("after_rel", ST_PAUSE, 2'd0);

    // song_done ignored in PAUSE
    pulse(1'b0, 1'b0, 1'b1);
    chk_all("pause_done", ST_PAUSE, 2'd0);

    // Play/pause toggle
    pulse(1'b1, 1'b0, 1'b0);
    chk_all("toggle_on", ST_PLAY, 2'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk_all("toggle_off", ST_PAUSE, 2'd0);

    // Skip from PAUSE resumes PAUSE; song advances on NEXT exit
    pulse(1'b0, 1'b1, 1'b0);
    chk_all("skip_next", ST_NEXT, 2'd0);
    tick();
    chk_all("skip_pause", ST_PAUSE, 2'd1);
    pulse(1'b1, 1'b0, 1'b0);
    chk_all("play_s1", ST_PLAY, 2'd1);

    // Auto-advance: GAP for exactly GAP cycles, then NEXT, then PLAY song 2
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < GAP; i++) begin
      chk_all($sformatf("gap%0d", i), ST_GAP, 2'd1);
      if (i < GAP - 1) tick();
    end
    tick();
    chk_all("auto_next", ST_NEXT, 2'd1);
    tick();
    chk_all("auto_play", ST_PLAY, 2'd2);

    // Manual skip while playing keeps playing
    pulse(1'b0, 1'b1, 1'b0);
    tick();
    chk_all("play_s3", ST_PLAY, 2'd3);

    // All three inputs together: next wins, wraps to 0, stays in PLAY
    pulse(1'b1, 1'b1, 1'b1);
    chk_all("prio_next", ST_NEXT, 2'd3);
    tick();
    chk_all("prio_play", ST_PLAY, 2'd0);

    // play_btn during GAP skips and resumes PAUSE
    pulse(1'b0, 1'b0, 1'b1);
    chk_all("gap_enter", ST_GAP, 2'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk_all("gap_playbtn", ST_NEXT, 2'd0);
    tick();
    chk_all("gap_pause", ST_PAUSE, 2'd1);

    // Reach song 3 playing, then let it finish on its own
    pulse(1'b0, 1'b1, 1'b0); tick();
    pulse(1'b0, 1'b1, 1'b0); tick();
    chk_all("pause_s3", ST_PAUSE, 2'd3);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    chk_all("end_gap", ST_GAP, 2'd3);
    repeat (GAP) tick();
    chk_all("end_next", ST_NEXT, 2'd3);
    tick();
`ifdef PLAYER_REPEAT_EN
    chk_all("end_wrap", ST_PLAY, 2'd0);
`else
    chk_all("end_wrap", ST_PAUSE, 2'd0);
    pulse(1'b1, 1'b0, 1'b0);
`endif
    chk_all("s0_play", ST_PLAY, 2'd0);

    // Reset mid-gap forces reset values, including the counter
    pulse(1'b0, 1'b0, 1'b1);
    tick();
    chk_all("mid_gap", ST_GAP, 2'd0);
    reset_n = 1'b0;
    #1;
    chk_all("gap_reset", ST_RST, 2'd0);
    chk("gap_cnt_clr", 32'(u_dut.u_gap.cnt_q), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_all("rst2_pause", ST_PAUSE, 2'd0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (GAP - 1) tick();
    chk_all("full_gap_last", ST_GAP, 2'd0);
    tick();
    chk_all("full_gap_next", ST_NEXT, 2'd0);
    tick();
    chk_all("full_gap_play", ST_PLAY, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
